// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode encodings, opcode check.
package alu_pkg;

  localparam int ALU_NB_DATA = 8;
  localparam int ALU_NB_OP   = 6;

  localparam logic [ALU_NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [ALU_NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [ALU_NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [ALU_NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [ALU_NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [ALU_NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [ALU_NB_OP-1:0] OP_SRL = 6'b000010;
  localparam logic [ALU_NB_OP-1:0] OP_NOR = 6'b100111;

  // True when the opcode is one the ALU implements.
  function automatic logic op_valid(input logic [ALU_NB_OP-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_uart_interface_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and
// saturates at TIMEOUT, flagging expiry while enabled.
module byte_timeout_counter #(
  parameter int TIMEOUT = 100000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_limit;

  assign at_limit  = (cnt_q == CW'(TIMEOUT));
  assign o_expired = i_enable && at_limit;

  // Next count: zero when idle or on a new byte, otherwise count up and hold at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear || !i_enable) begin
      cnt_d = '0;
    end else if (!at_limit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_uart_interface.sv
// Frame controller between uart_rx, alu and uart_tx: gathers A, B, opcode,
// presents them to the ALU, and returns one response byte per frame.
module alu_uart_interface
  import alu_pkg::*;
#(
  parameter int                 NB_DATA  = ALU_NB_DATA,
  parameter int                 NB_OP    = ALU_NB_OP,
  parameter int                 TIMEOUT  = 100000,
  parameter logic [NB_DATA-1:0] ERR_CODE = 8'hFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_A,
  output logic [NB_DATA-1:0] o_data_B,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_error
);

  typedef enum logic [2:0] {
    RX_A, RX_B, RX_OP, EXEC, SEND, WAIT_TX
  } state_t;

  state_t state_q, state_d;

  logic [NB_DATA-1:0] shadow_a_q, shadow_a_d;
  logic [NB_DATA-1:0] shadow_b_q, shadow_b_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               error_q, error_d;

  logic [NB_OP-1:0] op_in;
  logic             op_ok;
  logic             in_frame;
  logic             expired;

  // Only the low opcode bits matter; anything above is ignored.
  assign op_in    = i_rx_data[NB_OP-1:0];
  assign op_ok    = op_valid(op_in);
  assign in_frame = (state_q == RX_B) || (state_q == RX_OP);

  byte_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_enable  (in_frame),
    .i_clear   (i_rx_done),
    .o_expired (expired)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= RX_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a byte arriving together with expiry still wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_A:    if (i_rx_done) state_d = RX_B;
      RX_B:    if (i_rx_done) state_d = RX_OP;
               else if (expired) state_d = RX_A;
      RX_OP:   if (i_rx_done) state_d = op_ok ? EXEC : SEND;
               else if (expired) state_d = RX_A;
      EXEC:    state_d = SEND;
      SEND:    state_d = WAIT_TX;
      WAIT_TX: if (i_tx_done) state_d = RX_A;
      default: state_d = RX_A;
    endcase
  end

  // Datapath updates: shadow capture, atomic ALU operand load, response byte.
  always_comb begin
    shadow_a_d = shadow_a_q;
    shadow_b_d = shadow_b_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    error_d    = 1'b0;
    case (state_q)
      RX_A: begin
        if (i_rx_done) shadow_a_d = i_rx_data;
      end
      RX_B: begin
        if (i_rx_done) begin
          shadow_b_d = i_rx_data;
        end else if (expired) begin
          shadow_a_d = '0;
          shadow_b_d = '0;
        end
      end
      RX_OP: begin
        if (i_rx_done) begin
          if (op_ok) begin
            data_a_d = shadow_a_q;
            data_b_d = shadow_b_q;
            op_d     = op_in;
          end else begin
            tx_data_d = ERR_CODE;
            error_d   = 1'b1;
          end
        end else if (expired) begin
          shadow_a_d = '0;
          shadow_b_d = '0;
        end
      end
      EXEC: begin
        tx_data_d = i_alu_result;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shadow_a_q <= '0;
      shadow_b_q <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      shadow_a_q <= shadow_a_d;
      shadow_b_q <= shadow_b_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      error_q    <= error_d;
    end
  end

  // Outputs; the transmit request is a decode of the single-cycle SEND state.
  always_comb begin
    o_data_A   = data_a_q;
    o_data_B   = data_b_q;
    o_op       = op_q;
    o_tx_data  = tx_data_q;
    o_error    = error_q;
    o_tx_start = (state_q == SEND);
  end

endmodule

// File: doc/alu_uart_interface.md
Name: alu_uart_interface

Overview:
Frame controller between the UART receiver/transmitter pair and the combinational ALU. It collects three received bytes, in order operand A, operand B, opcode. It then drives the ALU inputs from registers, captures the ALU result, and hands that result to the UART transmitter as one response byte. It is the operand-producing and result-consuming end of the ALU interface, and sits in the top level between uart_rx, alu and uart_tx.

Parameters:
NB_DATA, 8, operand/result width; equals the UART byte width.
NB_OP, 6, ALU opcode width; taken from the low bits of the opcode byte.
TIMEOUT, 100000, maximum i_clk cycles between bytes of one frame before the frame is aborted.
ERR_CODE, 8'hFF, response byte sent for an unsupported opcode.

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_rx_data  in  NB_DATA  byte from UART receiver
i_rx_done  in  1  one-cycle strobe: i_rx_data valid
i_alu_result  in  NB_DATA  combinational ALU output
i_tx_done  in  1  one-cycle strobe: transmitter finished the byte
o_data_A  out  NB_DATA  ALU operand A (registered)
o_data_B  out  NB_DATA  ALU operand B (registered)
o_op  out  NB_OP  ALU opcode (registered)
o_tx_data  out  NB_DATA  byte to transmit (registered)
o_tx_start  out  1  one-cycle transmit request
o_error  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- Reset (asynchronous, active-high): state RX_A; all outputs 0; shadow registers and timeout counter cleared.
- States: RX_A, RX_B, RX_OP, EXEC, SEND, WAIT_TX.
- RX_A: on i_rx_done, latch shadow_A and go to RX_B.
- RX_B: on i_rx_done, latch shadow_B and go to RX_OP.
- RX_OP: on i_rx_done, check the opcode i_rx_data[NB_OP-1:0]. Upper bits are ignored.
  - Valid opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111.
  - Valid: at the same edge, o_data_A, o_data_B and o_op are updated together from shadow_A, shadow_B and the opcode. Go to EXEC.
  - Invalid: ALU outputs unchanged; o_tx_data <= ERR_CODE; o_error pulses one cycle; go to SEND.
- EXEC: exactly one cycle, letting the ALU settle. o_tx_data <= i_alu_result; go to SEND.
- SEND: o_tx_start = 1 for exactly this one cycle; go to WAIT_TX.
- WAIT_TX: stay until i_tx_done, then go to RX_A.
- Latency (valid opcode): opcode strobe at edge N, o_data_*/o_op updated at N, o_tx_data valid at N+1, o_tx_start high during cycle N+1..N+2.
- o_data_A, o_data_B and o_op hold their values until the next valid frame. A partial frame never alters them.
- Timeout: the counter runs only in RX_B and RX_OP and clears on every i_rx_done. When the count reaches TIMEOUT, return to RX_A and discard the shadow registers. No response is sent.
- i_rx_done in EXEC, SEND or WAIT_TX is dropped; the byte is lost and not queued.
- i_tx_done outside WAIT_TX is ignored.
- i_rx_done and the timeout expiry in the same cycle: the byte is accepted and the counter clears.
- Reset mid-frame or mid-transmit: immediately return to RX_A with outputs at 0. A transmitter already started is not aborted by this block.
- Arithmetic: this block performs none. Widths pass through unchanged.

Decomposition:
- Shared package alu_pkg: the eight opcode localparams, NB_OP and NB_DATA defaults, and an opcode-valid function. The ALU and its bench also use this package.
- Sub-module byte_timeout_counter (enable, clear, expired). A natural sub-module, but optional.
- State encoding is local to this block.

Test Plan:
- Reset, then rx 0x05, 0x03, 0x20 → o_data_A=0x05, o_data_B=0x03, o_op=100000; one cycle later o_tx_data=0x08 and o_tx_start pulses once; after i_tx_done, state is RX_A.
- rx 0x03, 0x05, 0x22 (SUB) → o_tx_data=0xFE; rx 0x80, 0x02, 0x03 (SRA) → o_tx_data=0xE0.
- After a valid frame, rx 0x11, 0x22, 0x3F → o_error pulses once, o_tx_data=0xFF, o_data_A/B/o_op keep their previous values.
- rx 0x0F, then idle TIMEOUT+1 cycles → no o_tx_start; then rx 0x0F, 0xF0, 0x24 → response 0x00.
- Frame in progress (A, B received), assert i_reset → all outputs 0; next frame 0x01, 0x01, 0x27 (NOR) → 0xFE.
- i_rx_done pulse during WAIT_TX → ignored; frame state is unchanged; after i_tx_done, a fresh 3-byte frame completes normally.
